// File: rtl/imem_sync.sv
// -----------------------------------------------------------------------------
// imem_sync -- synchronous instruction memory with a one-cycle fetch port and a
// byte-enabled load port.
//
// After reset the block fills every word with NOP_WORD, one word per cycle
// (INIT). It then raises ready and serves fetches and writes (RUN).
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset      asynchronous, active-high reset
//   req_valid  fetch request present
//   req_addr   byte address of the fetch
//   stall      hold the current response; accept no new request
//   flush      drop the current response; overrides stall and req_valid
//   wr_en      load-port word write strobe
//   wr_addr    load-port byte address
//   wr_data    load-port write data
//   wr_be      byte enables, bit i selects wr_data[8i+7:8i]
//   ready      initialisation complete
//   rsp_valid  response registers hold a valid fetch
//   rsp_instr  fetched instruction, little-endian
//   rsp_addr   req_addr of the fetch being returned
//   rsp_fault  2'b00 ok, 2'b01 misaligned, 2'b10 out of range
// -----------------------------------------------------------------------------
module imem_sync #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic        stall,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic        ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic [1:0]  rsp_fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] FAULT_OK    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE = 2'b10;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wbe;

  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_instr_q, rsp_instr_d;
  logic [31:0]   rsp_addr_q,  rsp_addr_d;
  logic [1:0]    rsp_fault_q, rsp_fault_d;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. The fill counter wraps back to zero on the same edge that
  // enters RUN, so it is already cleared for the next reset-initiated fill.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default first so no path
  // through the block leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH_WORDS - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = (state_q == ST_RUN);
  end

  // ---------------------------------------------------------------------------
  // Write port: the fill owns the array during INIT; afterwards the load port
  // writes only aligned, in-range addresses.
  // ---------------------------------------------------------------------------
  logic wr_aligned;
  logic wr_in_range;

  always_comb begin
    wr_aligned  = (wr_addr[1:0] == 2'b00);
    wr_in_range = (wr_addr[31:AW+2] == '0);
    mem_we      = 1'b0;
    mem_widx    = wr_addr[AW+1:2];
    mem_wdata   = wr_data;
    mem_wbe     = wr_be;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_widx  = cnt_q;
      mem_wdata = NOP_WORD;
      mem_wbe   = 4'hF;
    end else begin
      mem_we    = wr_en && wr_aligned && wr_in_range;
    end
  end

  // NOTE: the storage array has no reset; the INIT fill defines its contents,
  // which keeps it mappable onto RAM primitives.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wbe[i]) begin
          mem_q[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch port. The response register samples the array before this edge's
  // write lands, which gives read-first behaviour on a same-word collision.
  // ---------------------------------------------------------------------------
  logic          rd_misaligned;
  logic          rd_out_of_range;
  logic [AW-1:0] rd_idx;

  always_comb begin
    rd_misaligned   = (req_addr[1:0] != 2'b00);
    rd_out_of_range = (req_addr[31:AW+2] != '0);
    rd_idx          = req_addr[AW+1:2];

    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_fault_d = rsp_fault_q;

    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (ready && !stall) begin
      if (req_valid) begin
        rsp_valid_d = 1'b1;
        rsp_addr_d  = req_addr;
        // Misaligned wins when both faults apply.
        if (rd_misaligned) begin
          rsp_fault_d = FAULT_ALIGN;
          rsp_instr_d = NOP_WORD;
        end else if (rd_out_of_range) begin
          rsp_fault_d = FAULT_RANGE;
          rsp_instr_d = NOP_WORD;
        end else begin
          rsp_fault_d = FAULT_OK;
          rsp_instr_d = mem_q[rd_idx];
        end
      end else begin
        rsp_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= NOP_WORD;
      rsp_addr_q  <= '0;
      rsp_fault_q <= FAULT_OK;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_imem_sync.sv
// -----------------------------------------------------------------------------
// tb_imem_sync -- self-checking bench for imem_sync (DEPTH_WORDS = 64).
// Accepted fetches push their expected response into a scoreboard queue; a
// monitor pops and compares one entry after each following rising edge.
// Inputs change on the falling edge; outputs are sampled after the rising edge.
// -----------------------------------------------------------------------------
module tb_imem_sync;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        stall;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        ready;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_fault;

  imem_sync #(
    .DEPTH_WORDS (DEPTH),
    .NOP_WORD    (NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .stall     (stall),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .ready     (ready),
    .rsp_valid (rsp_valid),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_fault (rsp_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [1:0]  fault;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference behaviour of a fetch against the bench's memory model.
  function automatic exp_t expect_for(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    if (a[1:0] != 2'b00) begin
      e.fault = 2'b01;
      e.instr = NOP;
    end else if (a >= 32'(4 * DEPTH)) begin
      e.fault = 2'b10;
      e.instr = NOP;
    end else begin
      e.fault = 2'b00;
      e.instr = model[a[7:2]];
    end
    return e;
  endfunction

  // Reference behaviour of a load-port write.
  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] be);
    if (a[1:0] == 2'b00 && a < 32'(4 * DEPTH)) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) model[a[7:2]][8*i +: 8] = d[8*i +: 8];
      end
    end
  endfunction

  // Scoreboard monitor.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_instr !== e.instr || rsp_addr !== e.addr ||
          rsp_fault !== e.fault) begin
        n_fail++;
        $display("FAIL fetch_rsp: got v=%b instr=%h addr=%h fault=%b, want v=1 instr=%h addr=%h fault=%b",
                 rsp_valid, rsp_instr, rsp_addr, rsp_fault, e.instr, e.addr, e.fault);
      end
    end
  end

  // --- stimulus primitives ---------------------------------------------------
  task automatic drive_fetch(input logic [31:0] a);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    stall     = 1'b0;
    flush     = 1'b0;
    wr_en     = 1'b0;
    sb.push_back(expect_for(a));
  endtask

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    req_valid = 1'b0;
    wr_en     = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    wr_be     = be;
    model_write(a, d, be);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    wr_en     = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
  endtask

  // --- scenarios ---------------------------------------------------------------
  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    stall     = 1'b0;
    flush     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    wr_be     = '0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_instr !== NOP ||
        rsp_addr !== 32'h0 || rsp_fault !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b v=%b instr=%h addr=%h fault=%b, want 0 0 %h 0 00",
               ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault, NOP);
    end
  endtask

  // Release reset with junk fetch/write traffic present; INIT must ignore it.
  task automatic test_init_fill();
    int cycles = 0;
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h10;
    wr_en     = 1'b1;
    wr_addr   = 32'h10;
    wr_data   = 32'hDEAD_BEEF;
    wr_be     = 4'hF;
    while (cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      if (ready === 1'b1) break;
    end
    req_valid = 1'b0;
    wr_en     = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = NOP;
    n_checks++;
    if (cycles != int'(DEPTH) || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL init_length: ready after %0d cycles (ready=%b), want %0d", cycles, ready, DEPTH);
    end
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL init_ignores_req: rsp_valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_basic_fetch();
    drive_fetch(32'h3C);
    drive_write(32'h00, 32'h0023_07d3, 4'hF);
    drive_fetch(32'h00);
    drive_write(32'h04, 32'hAABB_CCDD, 4'b0101);
    drive_fetch(32'h04);
    idle();
    @(posedge clk);
    #2;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_drops_valid: rsp_valid=%b, want 0", rsp_valid);
    end
    n_checks++;
    if (model[1] !== 32'h00BB_00DD) begin
      n_fail++;
      $display("FAIL byte_merge_model: got %h, want 00bb00dd", model[1]);
    end
  endtask

  task automatic test_faults();
    drive_fetch(32'h06);
    drive_fetch(32'h100);
    drive_fetch(32'h102);
    drive_fetch(32'hFFFF_FFFC);
    idle();
  endtask

  // Dropped writes, then read every word back-to-back against the model.
  task automatic test_back_to_back();
    drive_write(32'h100, 32'hFFFF_FFFF, 4'hF);
    drive_write(32'h0A,  32'hFFFF_FFFF, 4'hF);
    drive_write(32'h4_0000, 32'hFFFF_FFFF, 4'hF);
    for (int i = 0; i < int'(DEPTH); i++) drive_fetch(32'(4 * i));
    idle();
  endtask

  task automatic test_stall_flush();
    drive_fetch(32'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall     = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h20 + 32'(4 * i);
      @(posedge clk);
      #2;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_instr !== model[0] || rsp_addr !== 32'h0 ||
          rsp_fault !== 2'b00) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got v=%b instr=%h addr=%h fault=%b, want 1 %h 0 00",
                 i, rsp_valid, rsp_instr, rsp_addr, rsp_fault, model[0]);
      end
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #2;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_over_stall: rsp_valid=%b, want 0", rsp_valid);
    end
    // Flush alone with a request present: nothing accepted.
    @(negedge clk);
    stall = 1'b0;
    @(posedge clk);
    #2;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_blocks_req: rsp_valid=%b, want 0", rsp_valid);
    end
    idle();
  endtask

  task automatic test_read_first();
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h08;
    wr_en     = 1'b1;
    wr_addr   = 32'h08;
    wr_data   = 32'h1111_1111;
    wr_be     = 4'hF;
    sb.push_back(expect_for(32'h08));
    model_write(32'h08, 32'h1111_1111, 4'hF);
    drive_fetch(32'h08);
    idle();
  endtask

  task automatic test_reset_mid_run();
    drive_fetch(32'h0C);
    @(posedge clk);
    #3;
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_instr !== NOP || rsp_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got rdy=%b v=%b instr=%h addr=%h, want 0 0 %h 0",
               ready, rsp_valid, rsp_instr, rsp_addr, NOP);
    end
    repeat (2) @(posedge clk);
    test_init_fill();
    // Earlier writes must have been overwritten by the refill.
    drive_fetch(32'h00);
    drive_fetch(32'h08);
    idle();
  endtask

  initial begin
    test_reset();
    test_init_fill();
    test_basic_fetch();
    test_faults();
    test_back_to_back();
    test_stall_flush();
    test_read_first();
    test_reset_mid_run();
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_sync.md
IMEM_SYNC -- requirements
Module: imem_sync

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, giving the number of 32-bit instruction words (power of two, 4..4096).
REQ-002 The block SHALL have parameter NOP_WORD, default 32'h00000013, giving the fill and fault-substitute instruction.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  fetch request present.
REQ-007 req_addr  input  32  byte address of fetch.
REQ-008 stall  input  1  hold current response; do not accept a new request.
REQ-009 flush  input  1  discard the current and in-flight response.
REQ-010 wr_en  input  1  load-port word write strobe.
REQ-011 wr_addr  input  32  load-port byte address.
REQ-012 wr_data  input  32  load-port write data.
REQ-013 wr_be  input  4  byte enables; bit i selects wr_data[8i+7:8i].
REQ-014 ready  output  1  initialisation complete; requests and writes accepted.
REQ-015 rsp_valid  output  1  response registers hold a valid fetch.
REQ-016 rsp_instr  output  32  fetched instruction, little-endian (lowest byte address in bits 7:0).
REQ-017 rsp_addr  output  32  req_addr of the fetch being returned.
REQ-018 rsp_fault  output  2  2'b00 ok, 2'b01 misaligned, 2'b10 out of range.

Function
REQ-019 State machine SHALL have two states: INIT and RUN.
REQ-020 In INIT, a word counter SHALL write NOP_WORD to word 0, 1, ... DEPTH_WORDS-1, one word per cycle, with ready=0.
REQ-021 After writing word DEPTH_WORDS-1, the block SHALL enter RUN on the next edge; ready SHALL be 1 in RUN only.
REQ-022 In INIT, req_valid and wr_en SHALL be ignored.
REQ-023 Read latency SHALL be 1 cycle: a request accepted at edge N appears on rsp_* after edge N, with rsp_valid=1.
REQ-024 A request SHALL be accepted when ready=1, req_valid=1, stall=0 and flush=0.
REQ-025 When ready=1, stall=0, flush=0 and req_valid=0, rsp_valid SHALL go to 0 at the next edge.
REQ-026 When stall=1 and flush=0, all rsp_* outputs SHALL hold their values.
REQ-027 flush=1 SHALL clear rsp_valid at the next edge and SHALL override stall and req_valid; no request is accepted that cycle.
REQ-028 Word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2].
REQ-029 If req_addr[1:0]!=0, the response SHALL carry rsp_fault=2'b01 and rsp_instr=NOP_WORD.
REQ-030 If the request is aligned and req_addr >= 4*DEPTH_WORDS, the response SHALL carry rsp_fault=2'b10 and rsp_instr=NOP_WORD.
REQ-031 When both fault conditions hold, misaligned (2'b01) SHALL take priority.
REQ-032 A write SHALL occur when ready=1 and wr_en=1; only bytes with wr_be set are updated.
REQ-033 Writes with wr_addr[1:0]!=0 or wr_addr >= 4*DEPTH_WORDS SHALL be silently dropped.
REQ-034 Writes SHALL be independent of stall and flush.
REQ-035 When a write and an accepted read target the same word in the same cycle, the read SHALL return the pre-write contents (read-first).

Reset
REQ-036 reset=1 SHALL, asynchronously, force state=INIT, counter=0, ready=0, rsp_valid=0, rsp_instr=NOP_WORD, rsp_addr=0 and rsp_fault=2'b00.
REQ-037 Reset asserted mid-INIT or mid-RUN SHALL restart the full NOP fill after release; prior memory contents are not preserved.

Verification
REQ-038 Reset release with DEPTH_WORDS=64 -> ready=0 for exactly 64 cycles, then 1; a fetch of 0x3C returns 32'h00000013 with fault 00.
REQ-039 Write 0x002307d3 to 0x00 with wr_be=4'hF, then fetch 0x00 -> next cycle rsp_valid=1, rsp_instr=0x002307d3, rsp_addr=0.
REQ-040 Write 0xAABBCCDD to 0x04 with wr_be=4'b0101 over NOP -> fetch 0x04 returns 0x00BB00DD.
REQ-041 Fetch 0x06 -> fault 01, rsp_instr=NOP; fetch 0x100 -> fault 10; fetch 0x102 -> fault 01; write to 0x100 leaves all words unchanged.
REQ-042 Fetch issued, then stall=1 for 3 cycles with req_addr changing -> rsp_* constant; flush=1 with stall=1 -> rsp_valid=0 next edge.
REQ-043 Same-cycle write of 0x11111111 and fetch at 0x08 -> response is the old word; a fetch at 0x08 on the following cycle returns 0x11111111; reset pulse mid-RUN -> ready=0 and rsp_valid=0 immediately.
